// File: rtl/ram_burst_reader.sv
// Burst read initiator for a 1-cycle-latency synchronous RAM, streaming words out through a prefetch FIFO.
// Optional: define BURST_CHECKSUM_EN to add a per-burst XOR checksum output.
module ram_burst_reader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 128,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              read_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef BURST_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q, issued, accepted;
  logic              rd_pend;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occupancy;
  logic              push, pop, can_issue, last_pop;

  assign push    = rd_pend;
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  // Reserve a slot for every word still on its way from the RAM.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(read_en) + OCC_W'(rd_pend);
  assign can_issue = occupancy < OCC_W'(FIFO_DEPTH);
  assign last_pop  = pop && ((accepted + LEN_W'(1)) == len_q);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= ram_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      read_en  <= 1'b0;
      rd_addr  <= '0;
      rd_pend  <= 1'b0;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
    end else begin
      rd_pend <= read_en;
      read_en <= 1'b0;
      done    <= 1'b0;
      if (pop) accepted <= accepted + LEN_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= burst_len;
            busy     <= 1'b1;
            accepted <= '0;
            if (burst_len == '0) begin
              issued <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              // First read goes out the cycle after start.
              read_en <= 1'b1;
              rd_addr <= base_addr;
              issued  <= LEN_W'(1);
              state   <= (burst_len == LEN_W'(1)) ? DRAIN : FETCH;
            end
          end
        end
        FETCH: begin
          if (can_issue) begin
            read_en <= 1'b1;
            rd_addr <= rd_addr + ADDR_W'(1);
            issued  <= issued + LEN_W'(1);
            if ((issued + LEN_W'(1)) == len_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BURST_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset)                       checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (pop)                    checksum <= checksum ^ m_data;
  end
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: behavioural RAM, stream/read/done loggers, hand-computed expectations.
module tb_ram_burst_reader;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 128;
  localparam int LEN_W  = 13;
  localparam int DEPTH  = 4;

  logic              clock, reset, start;
  logic [ADDR_W-1:0] base_addr, rd_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              busy, done, read_en, m_valid, m_ready;
  logic [DATA_W-1:0] ram_rdata, m_data;
`ifdef BURST_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  ram_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .burst_len(burst_len),
    .busy(busy), .done(done), .rd_addr(rd_addr), .read_en(read_en), .ram_rdata(ram_rdata),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef BURST_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0, n;

  logic [DATA_W-1:0] ram [4096];
  logic [DATA_W-1:0] got_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int rd_cyc_q[$], vld_cyc_q[$], done_cyc_q[$];
  int occ = 0;
  logic rv = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (read_en) ram_rdata <= ram[rd_addr];
  end

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {20'hA1B2C, a, 20'h3D4E5, ~a, 20'h6F708, a, 20'h9ABCD, a ^ 12'h5A5};
  endfunction

  // Loggers plus an independent FIFO fill model that flags any write into a full FIFO.
  always @(negedge clock) begin
    if (read_en) begin addr_q.push_back(rd_addr); rd_cyc_q.push_back(cyc); end
    if (m_valid && m_ready) got_q.push_back(m_data);
    if (m_valid) vld_cyc_q.push_back(cyc);
    if (done) done_cyc_q.push_back(cyc);
    if (reset) begin
      occ = 0;
      rv  = 1'b0;
    end else begin
      if (rv && occ == DEPTH && !(m_valid && m_ready)) begin
        errors++;
        $error("FAIL fifo_overflow: observed push at count=%0d required count<%0d", occ, DEPTH);
      end
      occ = occ + int'(rv) - int'(m_valid && m_ready);
      rv  = read_en;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    got_q.delete(); addr_q.delete(); rd_cyc_q.delete(); vld_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles && done_cyc_q.size() == 0; i++) tick();
    chk("done_seen", done_cyc_q.size() != 0, 1);
  endtask

  logic [ADDR_W-1:0] t2_addr [4];

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = word_of(ADDR_W'(i));
    ram[12'h100] = 128'h1;
    ram[12'h101] = 128'h2;
    ram[12'h102] = 128'h4;
    ram_rdata = '0;
    t2_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    reset = 1'b1; start = 1'b0; base_addr = '0; burst_len = '0; m_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read_en", read_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    reset = 1'b0;
    tick();

    // 1: base 0x010 len 4, cycle-exact timing, start during DONE ignored
    clear_logs();
    c0 = cyc; base_addr = 12'h010; burst_len = 13'd4; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_busy_c1", busy, 1);
    repeat (6) tick();
    chk("t1_done_c7", done, 1);
    chk("t1_busy_c7", busy, 1);
    start = 1'b1; base_addr = 12'h7FF; burst_len = 13'd4;
    tick(); start = 1'b0;
    chk("t1_busy_c8", busy, 0);
    chk("t1_done_c8", done, 0);
    repeat (4) tick();
    chk("t1_nrd", rd_cyc_q.size(), 4);
    chk("t1_nvld", vld_cyc_q.size(), 4);
    chk("t1_ndone", done_cyc_q.size(), 1);
    chk("t1_done_cyc", (done_cyc_q.size() > 0) ? done_cyc_q[0] - c0 : -1, 7);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rd_cyc", (i < rd_cyc_q.size()) ? rd_cyc_q[i] - c0 : -1, 1 + i);
      chk("t1_addr", (i < addr_q.size()) ? addr_q[i] : 'x, 12'h010 + 12'(i));
      chk("t1_vld_cyc", (i < vld_cyc_q.size()) ? vld_cyc_q[i] - c0 : -1, 3 + i);
      chk("t1_data", (i < got_q.size()) ? got_q[i] : 'x, word_of(12'h010 + 12'(i)));
    end

    // 2: address wrap 0xFFE..0x001
    clear_logs();
    base_addr = 12'hFFE; burst_len = 13'd4; start = 1'b1;
    tick(); start = 1'b0;
    wait_done(30);
    tick();
    chk("t2_nwords", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", (i < addr_q.size()) ? addr_q[i] : 'x, t2_addr[i]);
      chk("t2_data", (i < got_q.size()) ? got_q[i] : 'x, word_of(t2_addr[i]));
    end

    // 3: back-pressure for 10 cycles, len 16
    clear_logs();
    m_ready = 1'b0;
    base_addr = 12'h200; burst_len = 13'd16; start = 1'b1;
    tick(); start = 1'b0;
    repeat (9) tick();
    chk("t3_nrd_stalled", rd_cyc_q.size(), DEPTH);
    chk("t3_read_en_low", read_en, 0);
    chk("t3_m_valid", m_valid, 1);
    chk("t3_head", m_data, word_of(12'h200));
    chk("t3_none_taken", got_q.size(), 0);
    m_ready = 1'b1;
    wait_done(80);
    tick();
    chk("t3_nrd", rd_cyc_q.size(), 16);
    chk("t3_nwords", got_q.size(), 16);
    for (int i = 0; i < 16; i++)
      chk("t3_data", (i < got_q.size()) ? got_q[i] : 'x, word_of(12'h200 + 12'(i)));

    // 4: zero-length burst
    clear_logs();
    base_addr = 12'h123; burst_len = 13'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_done_c1", done, 1);
    chk("t4_busy_c1", busy, 1);
    tick();
    chk("t4_done_c2", done, 0);
    chk("t4_busy_c2", busy, 0);
    repeat (4) tick();
    chk("t4_nrd", rd_cyc_q.size(), 0);
    chk("t4_nvld", vld_cyc_q.size(), 0);
    chk("t4_ndone", done_cyc_q.size(), 1);

    // 5: reset mid-burst, then a clean len-2 burst
    clear_logs();
    base_addr = 12'h300; burst_len = 13'd8; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 20 && got_q.size() < 3; i++) tick();
    chk("t5_three_words", got_q.size() >= 3, 1);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_read_en", read_en, 0);
    chk("t5_rd_addr", rd_addr, 0);
    chk("t5_m_valid", m_valid, 0);
    chk("t5_m_data", m_data, 0);
    n = got_q.size();
    repeat (6) tick();
    chk("t5_no_more_words", got_q.size(), n);
    chk("t5_no_done", done_cyc_q.size(), 0);
    for (int i = 0; i < n; i++) chk("t5_prefix", got_q[i], word_of(12'h300 + 12'(i)));
    clear_logs();
    base_addr = 12'h040; burst_len = 13'd2; start = 1'b1;
    tick(); start = 1'b0;
    wait_done(20);
    tick();
    chk("t5_new_nwords", got_q.size(), 2);
    chk("t5_new_w0", (got_q.size() > 0) ? got_q[0] : 'x, word_of(12'h040));
    chk("t5_new_w1", (got_q.size() > 1) ? got_q[1] : 'x, word_of(12'h041));

`ifdef BURST_CHECKSUM_EN
    // 6: checksum of 1,2,4 and start-while-busy ignored
    clear_logs();
    base_addr = 12'h100; burst_len = 13'd3; start = 1'b1;
    tick();
    chk("t6_cleared", checksum, 0);
    base_addr = 12'h000; burst_len = 13'd5;
    tick(); start = 1'b0;
    wait_done(20);
    tick();
    chk("t6_checksum", checksum, 128'h7);
    chk("t6_nrd", rd_cyc_q.size(), 3);
    chk("t6_nwords", got_q.size(), 3);
    chk("t6_busy", busy, 0);
    repeat (3) tick();
    chk("t6_checksum_hold", checksum, 128'h7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
